// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage pipeline: combinational forwarding and stall/flush selects, plus a memory-wait FSM,
// a sticky timeout flag and saturating stall/flush counters. Every control output is combinational, with 0 cycles latency.
module hazard_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rs_E,
  input  logic [4:0]       Rt_E,
  input  logic [4:0]       writeReg_E,
  input  logic [4:0]       writeReg_M,
  input  logic [4:0]       writeReg_W,
  input  logic             regWrite_E,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic             memToReg_E,
  input  logic             memToReg_M,
  input  logic             branch_D,
  input  logic             jump_D,
  input  logic             pcSrc_D,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  input  logic             cnt_clear,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             forwardA_D,
  output logic             forwardB_D,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             lw_stall, br_stall, mem_stall, dep_stall;

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regWrite_M && writeReg_M != 5'd0 && writeReg_M == src)
      return 2'b10;
    else if (regWrite_W && writeReg_W != 5'd0 && writeReg_W == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forwardA_E = fwd_sel(Rs_E);
  assign forwardB_E = fwd_sel(Rt_E);
  assign forwardA_D = regWrite_M && writeReg_M != 5'd0 && writeReg_M == Rs_D;
  assign forwardB_D = regWrite_M && writeReg_M != 5'd0 && writeReg_M == Rt_D;

  assign lw_stall  = memToReg_E && writeReg_E != 5'd0 &&
                     (writeReg_E == Rs_D || writeReg_E == Rt_D);
  assign br_stall  = branch_D &&
                     ((regWrite_E && writeReg_E != 5'd0 && (writeReg_E == Rs_D || writeReg_E == Rt_D)) ||
                      (memToReg_M && writeReg_M != 5'd0 && (writeReg_M == Rs_D || writeReg_M == Rt_D)));
  assign mem_stall = mem_req_M && !mem_ready_M;
  assign dep_stall = lw_stall || br_stall;

  always_comb begin
    stall_F = dep_stall;
    stall_D = dep_stall;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = (pcSrc_D || jump_D) && !dep_stall;
    flush_E = dep_stall;
    flush_W = 1'b0;
    // A memory wait freezes the whole front of the pipe and bubbles W instead.
    if (mem_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_W = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_stall) state_d = WAIT;
      WAIT:    if (mem_ready_M || !mem_req_M) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + CNT_ONE;
      if (state_q == WAIT && wait_cnt == TIMEOUT_LAST)
        mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clear) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_F && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_ONE;
      if ((flush_D || flush_E) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus randomized cycles, all checked against a behavioural model.
module tb_hazard_unit;
  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W;
  logic regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M;
  logic branch_D, jump_D, pcSrc_D, mem_req_M, mem_ready_M, cnt_clear;
  logic [1:0] forwardA_E, forwardB_E;
  logic forwardA_D, forwardB_D, stall_F, stall_D, stall_E, stall_M;
  logic flush_D, flush_E, flush_W, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  // model state
  int   exp_sc, exp_fc, wait_run;
  logic exp_to, in_wait;

  hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .writeReg_E(writeReg_E), .writeReg_M(writeReg_M), .writeReg_W(writeReg_W),
    .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memToReg_E(memToReg_E), .memToReg_M(memToReg_M),
    .branch_D(branch_D), .jump_D(jump_D), .pcSrc_D(pcSrc_D),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M), .cnt_clear(cnt_clear),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [12:0] act_comb = {forwardA_E, forwardB_E, forwardA_D, forwardB_D,
                          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
  wire [4:0]  act_regs = {mem_timeout, stall_cnt, flush_cnt};

  // Expected combinational outputs in act_comb order, straight from the hazard rules.
  function automatic logic [12:0] exp_comb();
    logic [1:0] fae, fbe;
    logic fad, fbd, lw, br, st;
    fae = (regWrite_M && writeReg_M != 0 && writeReg_M == Rs_E) ? 2'd2 :
          (regWrite_W && writeReg_W != 0 && writeReg_W == Rs_E) ? 2'd1 : 2'd0;
    fbe = (regWrite_M && writeReg_M != 0 && writeReg_M == Rt_E) ? 2'd2 :
          (regWrite_W && writeReg_W != 0 && writeReg_W == Rt_E) ? 2'd1 : 2'd0;
    fad = regWrite_M && writeReg_M != 0 && writeReg_M == Rs_D;
    fbd = regWrite_M && writeReg_M != 0 && writeReg_M == Rt_D;
    lw  = memToReg_E && writeReg_E != 0 && (writeReg_E == Rs_D || writeReg_E == Rt_D);
    br  = branch_D && ((regWrite_E && writeReg_E != 0 && (writeReg_E == Rs_D || writeReg_E == Rt_D)) ||
                       (memToReg_M && writeReg_M != 0 && (writeReg_M == Rs_D || writeReg_M == Rt_D)));
    st  = lw || br;
    if (mem_req_M && !mem_ready_M)
      return {fae, fbe, fad, fbd, 7'b1111001};
    return {fae, fbe, fad, fbd, st, st, 1'b0, 1'b0, (pcSrc_D || jump_D) && !st, st, 1'b0};
  endfunction

  function automatic logic [4:0] exp_regs();
    logic [1:0] s, f;
    s = 2'(exp_sc);
    f = 2'(exp_fc);
    return {exp_to, s, f};
  endfunction

  task automatic clear_inputs();
    {Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W} = '0;
    {regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M} = '0;
    {branch_D, jump_D, pcSrc_D, mem_req_M, mem_ready_M, cnt_clear} = '0;
  endtask

  task automatic model_reset();
    exp_sc = 0; exp_fc = 0; exp_to = 1'b0; in_wait = 1'b0; wait_run = 0;
  endtask

  // One clock: model advances on the rising edge, returns on the falling edge.
  task automatic tick();
    logic [12:0] e;
    @(posedge clk);
    if (rst) begin
      e = exp_comb();
      if (cnt_clear) begin
        exp_sc = 0; exp_fc = 0;
      end else begin
        if (e[6] && exp_sc < CNT_MAX) exp_sc++;
        if ((e[2] || e[1]) && exp_fc < CNT_MAX) exp_fc++;
      end
      if (in_wait) begin
        wait_run++;
        if (wait_run >= MEM_TIMEOUT) exp_to = 1'b1;
        if (mem_ready_M || !mem_req_M) begin in_wait = 1'b0; wait_run = 0; end
      end else if (mem_req_M && !mem_ready_M) begin
        in_wait = 1'b1; wait_run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (act_regs !== 5'b0) begin
      fails++; $display("FAIL reset_async regs got=%b want=%b", act_regs, 5'b0);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (act_regs !== 5'b0) begin
      fails++; $display("FAIL reset_regs got=%b want=%b", act_regs, 5'b0);
    end
    Rs_E = 5'd7; writeReg_W = 5'd7; regWrite_W = 1'b1;
    #1;
    tests++;
    if (forwardA_E !== 2'b01) begin
      fails++; $display("FAIL reset_comb_follows forwardA_E got=%b want=01", forwardA_E);
    end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    writeReg_M = 5'd5; writeReg_W = 5'd5; regWrite_M = 1'b1; regWrite_W = 1'b1; Rs_E = 5'd5;
    #1;
    tests++;
    if (forwardA_E !== 2'b10) begin
      fails++; $display("FAIL fwd_m_priority got=%b want=10", forwardA_E);
    end
    regWrite_M = 1'b0;
    #1;
    tests++;
    if (forwardA_E !== 2'b01) begin
      fails++; $display("FAIL fwd_w got=%b want=01", forwardA_E);
    end
    Rs_E = 5'd0; writeReg_W = 5'd0; Rt_E = 5'd5; regWrite_M = 1'b1;
    #1;
    tests++;
    if (forwardA_E !== 2'b00 || forwardB_E !== 2'b10) begin
      fails++; $display("FAIL fwd_r0 got A=%b B=%b want A=00 B=10", forwardA_E, forwardB_E);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    memToReg_E = 1'b1; writeReg_E = 5'd8; Rt_D = 5'd8; pcSrc_D = 1'b1;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E, flush_D} !== 4'b1110) begin
      fails++; $display("FAIL load_use got=%b want=1110", {stall_F, stall_D, flush_E, flush_D});
    end
    tick();
    clear_inputs();
    #1;
    tests++;
    if (act_comb !== 13'b0) begin
      fails++; $display("FAIL load_use_release got=%b want=0", act_comb);
    end
    tests++;
    if (stall_cnt !== 2'd1 || flush_cnt !== 2'd1) begin
      fails++; $display("FAIL load_use_cnt got s=%0d f=%0d want s=1 f=1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_D = 1'b1; regWrite_E = 1'b1; writeReg_E = 5'd3; Rs_D = 5'd3;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b111) begin
      fails++; $display("FAIL br_stall got=%b want=111", {stall_F, stall_D, flush_E});
    end
    tick();
    regWrite_E = 1'b0; regWrite_M = 1'b1; writeReg_M = 5'd3; pcSrc_D = 1'b1;
    #1;
    tests++;
    if ({forwardA_D, stall_F, flush_D} !== 3'b101) begin
      fails++; $display("FAIL br_fwd got=%b want=101", {forwardA_D, stall_F, flush_D});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    mem_req_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({stall_F, stall_D, stall_E, stall_M, flush_W, flush_E, flush_D} !== 7'b1111100) begin
        fails++; $display("FAIL mem_wait cyc%0d got=%b want=1111100", i,
                          {stall_F, stall_D, stall_E, stall_M, flush_W, flush_E, flush_D});
      end
      tick();
    end
    mem_ready_M = 1'b1;
    #1;
    tests++;
    if ({stall_F, stall_D, stall_E, stall_M, flush_W} !== 5'b0) begin
      fails++; $display("FAIL mem_ready got=%b want=00000",
                        {stall_F, stall_D, stall_E, stall_M, flush_W});
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    mem_req_M = 1'b1;
    repeat (4) tick();
    tests++;
    if (mem_timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_early got=%b want=0", mem_timeout);
    end
    tick();
    tests++;
    if (mem_timeout !== 1'b1) begin
      fails++; $display("FAIL timeout_rise got=%b want=1", mem_timeout);
    end
    mem_ready_M = 1'b1;
    tick();
    clear_inputs();
    tick();
    tests++;
    if (mem_timeout !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
    end
    mem_req_M = 1'b1;
    repeat (2) tick();
    do_reset();
    // The wait restarts from idle, so the timeout needs the full count again.
    repeat (4) tick();
    tests++;
    if (mem_timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_after_rst got=%b want=0", mem_timeout);
    end
    tick();
    tests++;
    if (mem_timeout !== 1'b1) begin
      fails++; $display("FAIL timeout_rerise got=%b want=1", mem_timeout);
    end
    clear_inputs();
    do_reset();
  endtask

  task automatic test_counters();
    clear_inputs();
    memToReg_E = 1'b1; writeReg_E = 5'd9; Rs_D = 5'd9;
    repeat (5) tick();
    tests++;
    if (stall_cnt !== 2'd3) begin
      fails++; $display("FAIL cnt_saturate got=%0d want=3", stall_cnt);
    end
    cnt_clear = 1'b1;
    tick();
    tests++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      fails++; $display("FAIL cnt_clear got s=%0d f=%0d want 0", stall_cnt, flush_cnt);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
      Rs_E = 5'($urandom_range(0, 3)); Rt_E = 5'($urandom_range(0, 3));
      writeReg_E = 5'($urandom_range(0, 3)); writeReg_M = 5'($urandom_range(0, 3));
      writeReg_W = 5'($urandom_range(0, 3));
      {regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M} = 5'($urandom);
      {branch_D, jump_D, pcSrc_D} = 3'($urandom);
      mem_req_M   = ($urandom_range(0, 3) == 0);
      mem_ready_M = ($urandom_range(0, 2) != 0);
      cnt_clear   = ($urandom_range(0, 15) == 0);
      #1;
      tests++;
      if (act_comb !== exp_comb()) begin
        fails++; $display("FAIL rand_comb it%0d got=%b want=%b", i, act_comb, exp_comb());
      end
      tick();
      tests++;
      if (act_regs !== exp_regs()) begin
        fails++; $display("FAIL rand_regs it%0d got=%b want=%b", i, act_regs, exp_regs());
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
